// File: rtl/lsu_mem_ctrl_if.sv
// Purpose: bundles the CPU request/response and data-memory signals of lsu_mem_ctrl.
// Latency: none, wiring only.
// Backpressure: req_ready from the controller stalls the CPU request channel.
// Ports: req_* (CPU -> ctrl, req_ready back), resp_* (ctrl -> CPU),
//        mem_* (ctrl -> DM, mem_rdata back from DM).
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int WADDR_W = 10
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [ADDR_W-1:0]  req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic               resp_err;
    logic [31:0]        resp_rdata;
    logic               mem_en;
    logic [3:0]         mem_we;
    logic [WADDR_W-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // CPU + data-memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Purpose: RV32I load/store controller; splits word-crossing accesses, aligns and extends load data.
// Latency: response at T+1 (aligned store / error), T+2 (aligned load / split store), T+3 (split load).
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
// Ports: clk, rst (sync, active high); bus = lsu_mem_ctrl_if.slave carrying
//        req_* handshake, resp_* registered response pulse and mem_* DM access.
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32,
    parameter int WADDR_W   = 10
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {IDLE, RD_SECOND, RD_LAST, WR_SECOND, RESP} state_t;
    state_t state, state_nxt;

    // Request decode (meaningful only in IDLE)
    logic [1:0]         size, off;
    logic [2:0]         nbytes;
    logic [3:0]         lane_mask;
    logic [7:0]         m8;
    logic [63:0]        d64;
    logic [ADDR_W:0]    last_addr;
    logic [WADDR_W-1:0] w0;
    logic               illegal, split, err, hs, req_ready_c;

    // Captured request context and response
    logic [WADDR_W-1:0] r_w1;
    logic [31:0]        r_hi_wdata, r_word0, r_rdata;
    logic [3:0]         r_hi_we;
    logic [1:0]         r_off, r_size;
    logic               r_zext, r_split, r_err;

    logic [31:0]        lo_word, shifted, result;
    logic               mem_en_c;
    logic [3:0]         mem_we_c;
    logic [WADDR_W-1:0] mem_addr_c;
    logic [31:0]        mem_wdata_c;
    logic               resp_valid_c;

    assign req_ready_c = (state == IDLE) && !rst;
    assign hs          = bus.req_valid && req_ready_c;

    always_comb begin
        size = bus.req_funct3[1:0];
        off  = bus.req_addr[1:0];
        case (size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        // Loads: 3,6,7 illegal (size 3 covers 3 and 7). Stores: only 0..2 legal.
        illegal   = bus.req_we ? (bus.req_funct3 > 3'd2)
                               : ((size == 2'd3) || (bus.req_funct3 > 3'd5));
        last_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
        err       = illegal || ({1'b0, bus.req_addr} >= MEM_BYTES) || (last_addr >= MEM_BYTES);
        split     = (3'(off) + nbytes) > 3'd4;
        lane_mask = (nbytes == 3'd1) ? 4'b0001 : (nbytes == 3'd2) ? 4'b0011 : 4'b1111;
        m8        = {4'b0000, lane_mask} << off;
        d64       = {32'b0, bus.req_wdata} << {off, 3'b000};
        w0        = bus.req_addr[WADDR_W+1:2];
    end

    // Load merge: word0 is the registered first read for split loads, otherwise the live read.
    always_comb begin
        lo_word = r_split ? r_word0 : bus.mem_rdata;
        shifted = 32'({bus.mem_rdata, lo_word} >> {r_off, 3'b000});
        case (r_size)
            2'd0:    result = r_zext ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    result = r_zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            r_err      <= 1'b0;
            r_rdata    <= 32'b0;
            r_w1       <= '0;
            r_hi_wdata <= 32'b0;
            r_hi_we    <= 4'b0;
            r_off      <= 2'b0;
            r_size     <= 2'b0;
            r_zext     <= 1'b0;
            r_split    <= 1'b0;
            r_word0    <= 32'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                r_w1       <= w0 + WADDR_W'(1);
                r_hi_wdata <= d64[63:32];
                r_hi_we    <= m8[7:4];
                r_off      <= off;
                r_size     <= size;
                r_zext     <= bus.req_funct3[2];
                r_split    <= split;
                r_err      <= err;
                r_rdata    <= 32'b0;
            end
            if (state == RD_SECOND) r_word0 <= bus.mem_rdata;
            if (state == RD_LAST)   r_rdata <= result;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_en_c    = 1'b0;
        mem_we_c    = 4'b0;
        mem_addr_c  = w0;
        mem_wdata_c = d64[31:0];
        case (state)
            IDLE: begin
                if (hs) begin
                    if (err) begin
                        state_nxt = RESP;
                    end else begin
                        mem_en_c  = 1'b1;
                        mem_we_c  = bus.req_we ? m8[3:0] : 4'b0;
                        if (bus.req_we) state_nxt = split ? WR_SECOND : RESP;
                        else            state_nxt = split ? RD_SECOND : RD_LAST;
                    end
                end
            end
            RD_SECOND: begin
                mem_en_c   = 1'b1;
                mem_addr_c = r_w1;
                state_nxt  = RD_LAST;
            end
            RD_LAST: state_nxt = RESP;
            WR_SECOND: begin
                mem_en_c    = 1'b1;
                mem_we_c    = r_hi_we;
                mem_addr_c  = r_w1;
                mem_wdata_c = r_hi_wdata;
                state_nxt   = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset kills any access strobe in the same cycle, not only from the next one.
        if (rst) begin
            mem_en_c = 1'b0;
            mem_we_c = 4'b0;
        end
    end

    assign resp_valid_c   = (state == RESP) && !rst;
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_err   = resp_valid_c && r_err;
    assign bus.resp_rdata = resp_valid_c ? r_rdata : 32'b0;
    assign bus.mem_en     = mem_en_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Purpose: randomized and directed bench for lsu_mem_ctrl against a byte-addressed reference model.
// Latency: checks the response cycle of every accepted request against the expected latency.
// Backpressure: waits on req_ready before each request, bounded by a cycle budget.
module tb_lsu_mem_ctrl;
    localparam int MEM_WORDS = 1024;
    localparam int LIM       = MEM_WORDS * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32), .WADDR_W(10)) bus ();

    lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32), .WADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word-organised data memory driven by the DUT.
    logic [31:0] dm [MEM_WORDS];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == 4'b0) bus.mem_rdata <= dm[bus.mem_addr];
            else for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) dm[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Reference: flat byte array, plain little-endian byte arithmetic.
    logic [7:0] ref_mem [LIM];

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        err;
        bit [31:0] rdata;
        int        lat;
        int        nmem;
        int        nbytes;
    } txn_t;

    txn_t expq[$];
    txn_t cur;
    bit   busy = 0;
    int   cyc, nmem, wbytes, resp_cnt = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic txn_t model_apply(input bit we, input bit [2:0] f3,
                                         input bit [31:0] addr, input bit [31:0] wdata);
        txn_t t;
        int nb;
        bit ill, spl;
        longint last;
        bit [31:0] v;
        nb   = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        ill  = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
        last = longint'({32'b0, addr}) + nb - 1;
        spl  = (addr % 4) + nb > 4;
        t.we = we; t.addr = addr; t.wdata = wdata; t.nbytes = nb;
        t.err = ill || (last >= LIM);
        t.rdata = 0;
        if (t.err) begin
            t.lat = 1; t.nmem = 0;
        end else if (we) begin
            t.lat = spl ? 2 : 1; t.nmem = spl ? 2 : 1;
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
            t.lat = spl ? 3 : 2; t.nmem = spl ? 2 : 1;
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8*i));
            if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            t.rdata = v;
        end
        return t;
    endfunction

    // Per-strobe check: loads never write; every written byte lands at its own byte address.
    task automatic strobe_chk();
        longint ba, idx;
        bit ok;
        if (bus.mem_en) begin
            nmem++;
            if (!cur.we) check("load_no_write", bus.mem_we, 0);
            else for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) begin
                    ba  = longint'({bus.mem_addr, 2'b00}) + b;
                    idx = ba - longint'({32'b0, cur.addr});
                    ok  = 0;
                    if (idx >= 0 && idx < cur.nbytes)
                        ok = (bus.mem_wdata[8*b +: 8] == cur.wdata[8*idx +: 8]);
                    wbytes++;
                    check("store_lane", ok, 1);
                end
            end
        end
    endtask

    // Compare process.
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
        end else begin
            if (busy) begin
                cyc++;
                strobe_chk();
                if (bus.resp_valid) begin
                    check("resp_err",      bus.resp_err,   cur.err);
                    check("resp_rdata",    bus.resp_rdata, cur.rdata);
                    check("latency",       cyc,            cur.lat);
                    check("mem_strobes",   nmem,           cur.nmem);
                    check("bytes_written", wbytes,         (cur.we && !cur.err) ? cur.nbytes : 0);
                    last_rdata = bus.resp_rdata;
                    last_err   = bus.resp_err;
                    resp_cnt++;
                    busy = 0;
                end
            end else if (!(bus.req_valid && bus.req_ready)) begin
                check("idle_quiet", {bus.resp_valid, bus.mem_en}, 0);
            end
            if (bus.req_valid && bus.req_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_request", 1, 0);
                end else begin
                    cur = expq.pop_front();
                    busy = 1; cyc = 0; nmem = 0; wbytes = 0;
                    strobe_chk();
                end
            end
        end
    end

    task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wdata, output txn_t t);
        int n, start;
        t = model_apply(we, f3, addr, wdata);
        expq.push_back(t);
        #1;
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("handshake_timeout", n, 0);
        start = resp_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (resp_cnt == start && n < 20) begin @(posedge clk); n++; end
        if (resp_cnt == start) check("resp_timeout", n, 0);
    endtask

    task automatic directed(input string name, input bit we, input bit [2:0] f3,
                            input bit [31:0] addr, input bit [31:0] wdata,
                            input bit [31:0] exp_rd, input bit exp_err, input int exp_lat);
        txn_t t;
        do_req(we, f3, addr, wdata, t);
        check({name, "_model"}, {t.err, t.rdata, 8'(t.lat)}, {exp_err, exp_rd, 8'(exp_lat)});
        check({name, "_dut"},   {last_err, last_rdata},      {exp_err, exp_rd});
    endtask

    task automatic set_word(input int w, input bit [31:0] v);
        dm[w] = v;
        for (int i = 0; i < 4; i++) ref_mem[4*w + i] = v[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit [31:0] a;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
        for (int w = 0; w < MEM_WORDS; w++) set_word(w, $urandom);
        set_word(0, 32'h8081_8283);
        set_word(1, 32'h1122_3344);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready",  bus.req_ready,  0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_err",   bus.resp_err,   0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_mem_en",     bus.mem_en,     0);
        check("rst_mem_we",     bus.mem_we,     0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);
        @(posedge clk);

        // Loads: aligned, sub-word with extension, split word
        directed("lw0",  0, 3'd2, 0, 0, 32'h8081_8283, 0, 2);
        directed("lb1",  0, 3'd0, 1, 0, 32'hFFFF_FF82, 0, 2);
        directed("lbu1", 0, 3'd4, 1, 0, 32'h0000_0082, 0, 2);
        directed("lh2",  0, 3'd1, 2, 0, 32'hFFFF_8081, 0, 2);
        directed("lhu2", 0, 3'd5, 2, 0, 32'h0000_8081, 0, 2);
        directed("lw2",  0, 3'd2, 2, 0, 32'h3344_8081, 0, 3);

        // Reset while the split load sits in its second read
        t = model_apply(0, 3'd2, 2, 0);
        expq.push_back(t);
        #1;
        bus.req_we = 0; bus.req_funct3 = 3'd2; bus.req_addr = 2; bus.req_valid = 1'b1;
        @(negedge clk);
        check("abort_hs_ready", bus.req_ready, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_resp_valid", bus.resp_valid, 0);
        check("abort_mem_en",     bus.mem_en,     0);
        check("abort_req_ready",  bus.req_ready,  1);
        expq.delete();
        @(posedge clk);
        directed("lw0_after_rst", 0, 3'd2, 0, 0, 32'h8081_8283, 0, 2);

        // Split halfword store and readback
        directed("sh3",     1, 3'd1, 3, 32'h0000_ABCD, 32'h0, 0, 2);
        directed("lw0_sh",  0, 3'd2, 0, 0, 32'hCD81_8283, 0, 2);
        directed("lw4_sh",  0, 3'd2, 4, 0, 32'h1122_33AB, 0, 2);

        // Errors
        directed("lw_end",  0, 3'd2, LIM - 2, 0, 32'h0, 1, 1);
        directed("ld_f3_3", 0, 3'd3, 0, 0, 32'h0, 1, 1);
        directed("st_f3_4", 1, 3'd4, 0, 32'h1234_5678, 32'h0, 1, 1);
        directed("lw_last", 0, 3'd2, LIM - 4, 0, {ref_mem[LIM-1], ref_mem[LIM-2], ref_mem[LIM-3], ref_mem[LIM-4]}, 0, 2);

        // Randomized traffic biased toward low words and the end of memory
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 8)
                0, 1, 2, 3, 4: a = $urandom_range(0, 63);
                5, 6:          a = LIM - 8 + ($urandom % 12);
                default:       a = $urandom;
            endcase
            do_req(1'($urandom % 2), 3'($urandom % 8), a, $urandom, t);
            repeat ($urandom % 3) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller between the CPU's memory stage and the word-organised data memory (DM).
- Accepts one RV32I load/store per handshake (LB/LH/LW/LBU/LHU/SB/SH/SW selected by funct3).
- Drives DM with word address and byte enables.
- Splits accesses that cross a word boundary into two DM accesses.
- Aligns, merges and sign/zero-extends load data.
- Returns a registered response and stalls the pipeline through req_ready.

Parameters:
- MEM_WORDS, 1024: DM depth in 32-bit words; legal byte addresses are 0 .. MEM_WORDS*4-1.
- ADDR_W, 32: width of req_addr.
- WADDR_W, 10: width of mem_addr; must satisfy 2**WADDR_W >= MEM_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  request rejected (valid only with resp_valid).
- resp_rdata  out  32  load result (0 for stores and errors).
- mem_en  out  1  DM access strobe.
- mem_we  out  4  DM byte write enables; 0 = read.
- mem_addr  out  WADDR_W  DM word address.
- mem_wdata  out  32  DM write data.
- mem_rdata  in  32  DM read data, valid the cycle after a read strobe.

Behaviour:
Reset and idle outputs
- Reset values: req_ready=0 while rst=1, then 1; resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0.
- rst forces state IDLE and discards any in-flight access and pending response.
- req_ready=1 only in IDLE. Handshake = req_valid & req_ready.
- mem_* outputs are combinational from the request in IDLE and from internal registers in other states.
- mem_addr/mem_wdata are don't-care when mem_en=0.

Request decode
- Size: funct3[1:0] (0=byte, 1=half, 2=word). Load extension: funct3[2]=0 sign-extend, 1 zero-extend.
- Illegal funct3: loads 3,6,7; stores 3..7.
- off = addr[1:0]; w0 = addr[WADDR_W+1:2]; w1 = w0+1.
- Access is split when off+bytes > 4, i.e. half with off=3 or word with off!=0.
- Error when: funct3 is illegal, OR last byte address (addr+bytes-1) >= MEM_WORDS*4, OR addr >= MEM_WORDS*4.
- An error issues no mem_en and the request is accepted; resp_valid=1, resp_err=1, resp_rdata=0 in cycle T+1.

Store lane placement (little-endian)
- D64 = zero-extend(req_wdata, 64) << 8*off.
- M8 = ({bytes{1}}) << off.
- First access: word w0, mem_wdata=D64[31:0], mem_we=M8[3:0].
- Second access (split only): word w1, mem_wdata=D64[63:32], mem_we=M8[7:4].

Load merge
- Form {word1, word0} >> 8*off, take the low `bytes` bytes, then extend.
- For an unsplit access, word1 is don't-care.

State machine (T = handshake cycle)
- IDLE: on handshake, first access issued in T.
  - Error -> RESP.
  - Unsplit load -> RD_LAST.
  - Split load -> RD_SECOND.
  - Unsplit store -> RESP.
  - Split store -> WR_SECOND.
- RD_SECOND: issue read w1; capture mem_rdata as word0 -> RD_LAST.
- RD_LAST: capture mem_rdata (word0 or word1); compute result into resp regs -> RESP.
- WR_SECOND: issue second write -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. A new request may be accepted in the cycle after RESP.

Timing (resp_valid cycle)
- Aligned store or error: T+1.
- Aligned load or split store: T+2.
- Split load: T+3.

Test Plan:
- DM[0]=0x80818283, DM[1]=0x11223344; LW addr 0 -> one read of word 0 at T, resp_valid at T+2, rdata=0x80818283, err=0.
- LB addr 1 -> 0xFFFFFF82; LBU addr 1 -> 0x00000082; LH addr 2 -> 0xFFFF8081; LHU addr 2 -> 0x00008081.
- LW addr 2 -> mem reads of words 0 (T) and 1 (T+1), resp at T+3, rdata=0x33448081.
- SH addr 3 wdata 0x0000ABCD:
  - Expected writes: word 0 we=1000 with byte3=0xCD at T, then word 1 we=0001 with byte0=0xAB at T+1; resp at T+2.
  - Follow-up reads: LW 0 -> 0xCD818283; LW 4 -> 0x112233AB.
- Error cases, each resp_err=1 at T+1 with no mem_en:
  - LW addr MEM_WORDS*4-2 (crosses end of memory).
  - Load with funct3=3.
  - Store with funct3=4.
- Reset mid-access: rst=1 in RD_SECOND of a split load.
  - Required: next cycle has no resp_valid and mem_en=0.
  - After rst release, req_ready=1 and LW 0 completes normally with 0x80818283.
